// File: rtl/gstmcu_pkg.sv
// Shared types for the GSTMCU bus engine: bus half-state encoding and
// 68000 function-code constants.
package gstmcu_pkg;

  // 68000 half-states plus the DTACK wait state (SW) and the 6800/VPA wait (SV)
  typedef enum logic [3:0] {
    IDLE, S0, S1, S2, S3, S4, S5, S6, S7, SW, SV
  } bus_state_e;

  localparam logic [2:0] FC_UD   = 3'b001;
  localparam logic [2:0] FC_UP   = 3'b010;
  localparam logic [2:0] FC_SD   = 3'b101;
  localparam logic [2:0] FC_SP   = 3'b110;
  localparam logic [2:0] FC_IACK = 3'b111;

endpackage

// File: rtl/m68k_bus_initiator_e_clock_gen.sv
// 6800 E clock generator. A free-running counter advanced on the 8 MHz
// rising-phase enable; E is high for the last E_HIGH counts of each period.
// e_vma_slot marks the count at which a VPA cycle may assert VMA_N, e_fall
// marks the count whose en1 wraps the counter (E falling edge).
module e_clock_gen #(
  parameter int E_LOW  = 6,
  parameter int E_HIGH = 4
) (
  input  logic clk32,
  input  logic resb,
  input  logic mhz8_en1,
  output logic E,
  output logic e_vma_slot,
  output logic e_fall
);
  import gstmcu_pkg::*;

  localparam int PERIOD = E_LOW + E_HIGH;
  localparam int CW     = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST_C = CW'(PERIOD - 1);
  localparam logic [CW-1:0] ELOW_C = CW'(E_LOW);
  localparam logic [CW-1:0] SLOT_C = CW'(E_LOW - 3);

  logic [CW-1:0] e_cnt_q, e_cnt_d;

  // Next count: wrap at the end of the E period
  always_comb begin
    e_cnt_d = e_cnt_q + CW'(1);
    if (e_cnt_q == LAST_C) e_cnt_d = '0;
  end

  // E period counter, advanced once per 8 MHz clock
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb)         e_cnt_q <= '0;
    else if (mhz8_en1) e_cnt_q <= e_cnt_d;
  end

  assign E          = (e_cnt_q >= ELOW_C);
  assign e_vma_slot = (e_cnt_q == SLOT_C);
  assign e_fall     = (e_cnt_q == LAST_C);

endmodule

// File: rtl/m68k_bus_initiator.sv
// 68000-compatible bus master: turns a single-word req/ack request into an
// asynchronous 68000 cycle (DTACK_N terminated) or a 6800 synchronous cycle
// (VPA_N terminated, VMA_N/E). Half-states advance on the 8 MHz phase enables.
// Optional build macro BUSINIT_TIMEOUT_EN adds a wait-state watchdog that
// forces termination after TIMEOUT_CYCLES 8 MHz clocks of waiting.
module m68k_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int E_LOW          = 6,
  parameter int E_HIGH         = 4
) (
  input  logic        clk32,
  input  logic        resb,
  input  logic        mhz8_en1,
  input  logic        mhz8_en2,
  input  logic        req,
  input  logic        req_rw,
  input  logic [22:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  input  logic [2:0]  req_fc,
  output logic        busy,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        rsp_vpa,
  output logic        rsp_tmo,
  output logic [22:0] A,
  output logic [15:0] DOUT,
  output logic        DOE,
  input  logic [15:0] DIN,
  output logic        AS_N,
  output logic        UDS_N,
  output logic        LDS_N,
  output logic        VMA_N,
  output logic        RW,
  output logic [2:0]  FC,
  output logic        E,
  input  logic        DTACK_N,
  input  logic        VPA_N
);
  import gstmcu_pkg::*;

  bus_state_e  state_q, state_d, term_state;
  logic [22:0] a_q, a_d;
  logic [2:0]  fc_q, fc_d;
  logic        rw_q, rw_d;
  logic [15:0] dout_q, dout_d;
  logic [1:0]  be_q, be_d;
  logic        as_n_q, as_n_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d;
  logic        vma_n_q, vma_n_d, doe_q, doe_d;
  logic        busy_q, busy_d, ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rsp_vpa_q, rsp_vpa_d, rsp_tmo_q, rsp_tmo_d;
  logic        dtack_s1_q, dtack_s2_q, vpa_s1_q, vpa_s2_q;
  logic        e_vma_slot, e_fall;
  logic        tmo_hit;

  e_clock_gen #(
    .E_LOW (E_LOW),
    .E_HIGH(E_HIGH)
  ) u_e_clock_gen (
    .clk32     (clk32),
    .resb      (resb),
    .mhz8_en1  (mhz8_en1),
    .E         (E),
    .e_vma_slot(e_vma_slot),
    .e_fall    (e_fall)
  );

  // Two-flop synchronisers for the asynchronous cycle terminators
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      dtack_s1_q <= 1'b1;
      dtack_s2_q <= 1'b1;
      vpa_s1_q   <= 1'b1;
      vpa_s2_q   <= 1'b1;
    end else begin
      dtack_s1_q <= DTACK_N;
      dtack_s2_q <= dtack_s1_q;
      vpa_s1_q   <= VPA_N;
      vpa_s2_q   <= vpa_s1_q;
    end
  end

  // Terminator decision at an en2 check point: DTACK wins over VPA, otherwise wait
  always_comb begin
    if (!dtack_s2_q)    term_state = S5;
    else if (!vpa_s2_q) term_state = SV;
    else                term_state = S4;
  end

`ifdef BUSINIT_TIMEOUT_EN
  localparam logic [6:0] TMO_LAST = 7'(TIMEOUT_CYCLES - 1);
  logic [6:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog: count 8 MHz clocks spent waiting for DTACK or for the VPA cycle
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_hit   = 1'b0;
    if (state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else if (mhz8_en1 && ((state_q == S4) ||
                 ((state_q == SV) && !rsp_vpa_q && !rsp_tmo_q))) begin
      tmo_cnt_d = tmo_cnt_q + 7'd1;
      tmo_hit   = (tmo_cnt_q == TMO_LAST);
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end

  assign rsp_tmo = rsp_tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign rsp_tmo = 1'b0;
`endif

  // Bus sequencer: half-state transitions and pin/response updates
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    fc_d      = fc_q;
    rw_d      = rw_q;
    dout_d    = dout_q;
    be_d      = be_q;
    as_n_d    = as_n_q;
    uds_n_d   = uds_n_q;
    lds_n_d   = lds_n_q;
    vma_n_d   = vma_n_q;
    doe_d     = doe_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    rsp_vpa_d = rsp_vpa_q;
    rsp_tmo_d = rsp_tmo_q;
    unique case (state_q)
      IDLE: if (mhz8_en1 && req) begin
        state_d   = S0;
        a_d       = req_addr;
        fc_d      = req_fc;
        rw_d      = req_rw;
        dout_d    = req_wdata;
        be_d      = req_be;
        busy_d    = 1'b1;
        rsp_vpa_d = 1'b0;
        rsp_tmo_d = 1'b0;
      end
      S0: if (mhz8_en2) state_d = S1;
      S1: if (mhz8_en1) begin
        state_d = S2;
        as_n_d  = 1'b0;
        if (rw_q) begin
          uds_n_d = ~be_q[1];
          lds_n_d = ~be_q[0];
        end else begin
          doe_d = 1'b1;
        end
      end
      S2: if (mhz8_en2) state_d = S3;
      S3: if (mhz8_en1) begin
        state_d = S4;
        if (!rw_q) begin
          uds_n_d = ~be_q[1];
          lds_n_d = ~be_q[0];
        end
      end
      // S4 is entered on en1, so an en1 seen here means a wait state began
      S4: begin
        if (mhz8_en2)      state_d = term_state;
        else if (mhz8_en1) state_d = SW;
      end
      SW: if (mhz8_en2) state_d = rsp_tmo_q ? S5 : term_state;
      SV: begin
        if (mhz8_en1) begin
          if (vma_n_q && !rsp_vpa_q && e_vma_slot) begin
            vma_n_d = 1'b0;
          end else if (!vma_n_q && e_fall) begin
            if (rw_q) rdata_d = DIN;
            vma_n_d   = 1'b1;
            rsp_vpa_d = 1'b1;
          end
        end else if (mhz8_en2 && (rsp_vpa_q || rsp_tmo_q)) begin
          state_d = S5;
        end
      end
      S5: if (mhz8_en1) state_d = S6;
      // Read data already captured on the VPA and timeout paths
      S6: if (mhz8_en2) begin
        state_d = S7;
        if (rw_q && !rsp_vpa_q && !rsp_tmo_q) rdata_d = DIN;
        as_n_d  = 1'b1;
        uds_n_d = 1'b1;
        lds_n_d = 1'b1;
      end
      S7: if (mhz8_en1) begin
        state_d = IDLE;
        doe_d   = 1'b0;
        busy_d  = 1'b0;
        ack_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      rdata_d   = 16'hFFFF;
      rsp_tmo_d = 1'b1;
      rsp_vpa_d = rsp_vpa_q;
      vma_n_d   = 1'b1;
    end
  end

  // Sequencer and bus-pin registers; reset negates every strobe at once
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state_q   <= IDLE;
      a_q       <= '0;
      fc_q      <= '0;
      rw_q      <= 1'b1;
      dout_q    <= '0;
      be_q      <= '0;
      as_n_q    <= 1'b1;
      uds_n_q   <= 1'b1;
      lds_n_q   <= 1'b1;
      vma_n_q   <= 1'b1;
      doe_q     <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      rsp_vpa_q <= 1'b0;
      rsp_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      fc_q      <= fc_d;
      rw_q      <= rw_d;
      dout_q    <= dout_d;
      be_q      <= be_d;
      as_n_q    <= as_n_d;
      uds_n_q   <= uds_n_d;
      lds_n_q   <= lds_n_d;
      vma_n_q   <= vma_n_d;
      doe_q     <= doe_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      rsp_vpa_q <= rsp_vpa_d;
      rsp_tmo_q <= rsp_tmo_d;
    end
  end

  assign busy    = busy_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign rsp_vpa = rsp_vpa_q;
  assign A       = a_q;
  assign DOUT    = dout_q;
  assign DOE     = doe_q;
  assign AS_N    = as_n_q;
  assign UDS_N   = uds_n_q;
  assign LDS_N   = lds_n_q;
  assign VMA_N   = vma_n_q;
  assign RW      = rw_q;
  assign FC      = fc_q;

endmodule
